// File: rtl/generic_fifo_write_packer.sv
// generic_fifo_write_packer
//
// Packs GENERIC_PACKER_RATIO narrow upstream beats (lane 0 first) into one
// FIFO-width word and writes it into a generic FIFO, throttled by the FIFO's
// almost_full. An end-of-packet beat flushes a partially filled word; lanes
// that never received a beat are zero and their write_mask bit is clear.
//
// Ports
//   clk               single clock, all state on posedge
//   reset_poweron     synchronous active-high reset (priority over clear)
//   clear             synchronous flush, same effect as reset
//   in_valid/in_ready upstream handshake, beat taken when both high
//   in_data           beat payload
//   in_eop            last beat of packet, closes the current word
//   write             FIFO write strobe (combinational from registered state)
//   write_data        packed word, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   write_mask        bit k set when lane k holds a beat
//   write_eop         word closes a packet
//   fifo_almost_full  FIFO almost_full; no write issued while high
//   word_count        words written since reset/clear, wraps

// One assembly lane: holds the beat parked in this lane and presents the
// lane contents merged with the incoming beat, so a completing beat can be
// folded into the outgoing word in the same cycle it is accepted.
module generic_fifo_write_packer_lane #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                flush_i,       // reset or clear
  input  logic                sel_i,         // lane pointer points here
  input  logic                store_i,       // park a non-completing beat
  input  logic                drop_i,        // word completed, empty the lane
  input  logic [IN_WIDTH-1:0] data_i,
  output logic [IN_WIDTH-1:0] merged_data_o,
  output logic                merged_vld_o
);
  logic [IN_WIDTH-1:0] data_q;
  logic                vld_q;

  always_ff @(posedge clk) begin
    if (flush_i || drop_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (store_i) begin
      data_q <= data_i;
      vld_q  <= 1'b1;
    end
  end

  // Lanes above the pointer were emptied on the last completion, so they
  // merge as zero with a clear mask bit.
  assign merged_data_o = sel_i ? data_i : data_q;
  assign merged_vld_o  = sel_i | vld_q;
endmodule

module generic_fifo_write_packer #(
  parameter int GENERIC_PACKER_IN_WIDTH    = 8,
  parameter int GENERIC_PACKER_RATIO       = 4,
  parameter int GENERIC_PACKER_COUNT_WIDTH = 16
) (
  input  logic                                                     clk,
  input  logic                                                     reset_poweron,
  input  logic                                                     clear,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [GENERIC_PACKER_IN_WIDTH-1:0]                       in_data,
  input  logic                                                     in_eop,
  output logic                                                     write,
  output logic [GENERIC_PACKER_IN_WIDTH*GENERIC_PACKER_RATIO-1:0]  write_data,
  output logic [GENERIC_PACKER_RATIO-1:0]                          write_mask,
  output logic                                                     write_eop,
  input  logic                                                     fifo_almost_full,
  output logic [GENERIC_PACKER_COUNT_WIDTH-1:0]                    word_count
);
  localparam int IW                        = GENERIC_PACKER_IN_WIDTH;
  localparam int NUM_LANES                 = GENERIC_PACKER_RATIO;
  localparam int CW                        = GENERIC_PACKER_COUNT_WIDTH;
  localparam int GENERIC_PACKER_OUT_WIDTH  = IW * NUM_LANES;
  localparam int GENERIC_PACKER_LANE_WIDTH = $clog2(NUM_LANES);
  localparam int LW                        = GENERIC_PACKER_LANE_WIDTH;

  // Assembly stage
  logic [LW-1:0]                       lane_q, lane_d;
  logic [NUM_LANES-1:0]                lane_sel;
  logic [NUM_LANES-1:0][IW-1:0]        merged_data;
  logic [NUM_LANES-1:0]                merged_vld;

  // Output stage
  logic                                out_valid_q, out_valid_d;
  logic [GENERIC_PACKER_OUT_WIDTH-1:0] write_data_q, write_data_d;
  logic [NUM_LANES-1:0]                write_mask_q, write_mask_d;
  logic                                write_eop_q, write_eop_d;
  logic [CW-1:0]                       word_count_q, word_count_d;

  logic flush, accept, last_lane, complete;

  assign flush     = reset_poweron | clear;

  // write never looks at in_*, so the FIFO sees no combinational path from
  // upstream; in_ready only frees up when the output word is leaving.
  assign write     = out_valid_q & ~fifo_almost_full;
  assign in_ready  = ~out_valid_q | write;
  assign accept    = in_valid & in_ready;
  assign last_lane = (lane_q == LW'(NUM_LANES - 1));
  assign complete  = accept & (last_lane | in_eop);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_sel[k] = (lane_q == LW'(k));

    generic_fifo_write_packer_lane #(
      .IN_WIDTH (IW)
    ) u_lane (
      .clk           (clk),
      .flush_i       (flush),
      .sel_i         (lane_sel[k]),
      .store_i       (accept & ~complete & lane_sel[k]),
      .drop_i        (complete),
      .data_i        (in_data),
      .merged_data_o (merged_data[k]),
      .merged_vld_o  (merged_vld[k])
    );
  end

  always_comb begin
    lane_d       = lane_q;
    out_valid_d  = out_valid_q;
    write_data_d = write_data_q;
    write_mask_d = write_mask_q;
    write_eop_d  = write_eop_q;
    word_count_d = word_count_q;

    if (write) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + CW'(1);
    end

    // A completing beat may reload the output register in the same cycle
    // the old word drains, keeping 1 word per RATIO cycles with no bubble.
    if (complete) begin
      lane_d       = '0;
      out_valid_d  = 1'b1;
      write_data_d = merged_data;
      write_mask_d = merged_vld;
      write_eop_d  = in_eop;
    end else if (accept) begin
      lane_d = lane_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      lane_q       <= '0;
      out_valid_q  <= 1'b0;
      write_data_q <= '0;
      write_mask_q <= '0;
      write_eop_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      lane_q       <= lane_d;
      out_valid_q  <= out_valid_d;
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      write_eop_q  <= write_eop_d;
      word_count_q <= word_count_d;
    end
  end

  assign write_data = write_data_q;
  assign write_mask = write_mask_q;
  assign write_eop  = write_eop_q;
  assign word_count = word_count_q;
endmodule
